// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;
  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10
  } fault_cause_e;
endpackage

// File: rtl/fetch_unit_pc_gen.sv
// pc_gen: next-fetch PC register, fetch address mux and bad-address check
module pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  input  logic         hold_i,
  input  logic [31:0]  pc_d1_i,
  input  logic         load_i,
  output logic [31:0]  imem_addr_o,
  output logic         bad_o,
  output fault_cause_e cause_o
);
  localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - INSTR_BYTES);
  logic [31:0] pc_q, pc_d;
  // Pick the fetch address and classify it; misalignment outranks range
  always_comb begin
    imem_addr_o = redirect_i ? redirect_pc_i : hold_i ? pc_d1_i : pc_q;
    cause_o = imem_addr_o[1:0] != 2'b00 ? FC_MISALIGN : imem_addr_o > LAST_PC ? FC_RANGE : FC_NONE;
    bad_o = cause_o != FC_NONE;
    pc_d = load_i ? imem_addr_o + 32'(INSTR_BYTES) : pc_q;
  end
  // Next-fetch PC advances only past an accepted good fetch
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and fetch alignment ahead of a registered imem
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);
  logic [31:0] pc_d1_q, pc_d1_d, cnt_q, cnt_d;
  logic v_d1_q, v_d1_d, fault_q, fault_d, take, hold, bad;
  fault_cause_e cause_q, cause_d, cause;
  assign take = redirect | (~fault_q & ~stall);
  assign hold = stall & ~fault_q;
  pc_gen #(.RESET_PC(RESET_PC), .MEM_SIZE(MEM_SIZE)) u_pc_gen (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .hold_i       (hold),
    .pc_d1_i      (pc_d1_q),
    .load_i       (take & ~bad),
    .imem_addr_o  (imem_addr),
    .bad_o        (bad),
    .cause_o      (cause)
  );
  // A taken fetch either delivers next cycle or enters/updates the fault
  always_comb begin
    pc_d1_d = take && !bad ? imem_addr : pc_d1_q;
    v_d1_d = take ? !bad : v_d1_q;
    fault_d = take ? bad : fault_q;
    cause_d = take ? cause : cause_q;
    cnt_d = cnt_q + 32'(v_d1_q & ~stall & ~redirect);
  end
  // Fetch tracking, fault and accepted-instruction counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_d1_q <= '0;
      v_d1_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= FC_NONE;
      cnt_q <= '0;
    end else begin
      pc_d1_q <= pc_d1_d;
      v_d1_q <= v_d1_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
    end
  end
  assign if_pc = pc_d1_q;
  assign if_valid = v_d1_q;
  assign if_instr = v_d1_q ? imem_instr : NOP_INSTR;
  assign fault = fault_q;
  assign fault_cause = cause_q;
  assign fetch_count = cnt_q;
endmodule
